// File: rtl/lsu_if.sv
// Request and memory-port signal bundle for the load/store unit.
// The slave modport is the LSU's view; master is the core/memory side.
interface lsu_if;
   logic        req_i;
   logic        we_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [31:0] rdata_o;
   logic        mem_en_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;

   modport slave (
      input  req_i, we_i, funct3_i, addr_i, wdata_i, mem_rdata_i,
      output busy_o, done_o, err_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output req_i, we_i, funct3_i, addr_i, wdata_i, mem_rdata_i,
      input  busy_o, done_o, err_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/lsu.sv
// Load/store unit: byte/half/word accesses onto a word-wide synchronous memory,
// with read-modify-write for sub-word stores and alignment/legality checking.
module lsu (
   input  logic clk_i,
   input  logic rst_ni,
   lsu_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StDone} state_e;

   state_e      state_q, state_d;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        req_illegal;
   logic        req_misaligned;
   logic        req_err;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_val;
   logic [31:0] merged;

   // Legality/alignment of the request currently presented on the inputs.
   always_comb begin
      req_illegal    = (bus.funct3_i == 3'b011) || (bus.funct3_i[2:1] == 2'b11) ||
                       (bus.we_i && bus.funct3_i[2]);
      req_misaligned = 1'b0;
      case (bus.funct3_i[1:0])
         2'b01:   req_misaligned = bus.addr_i[0];
         2'b10:   req_misaligned = (bus.addr_i[1:0] != 2'b00);
         default: req_misaligned = 1'b0;
      endcase
      req_err = req_illegal || req_misaligned;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req_i) begin
               if (req_err) begin
                  state_d = StDone;
               end else if (!bus.we_i) begin
                  state_d = StRd;
               end else if (bus.funct3_i[1:0] == 2'b10) begin
                  state_d = StWr;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd:    state_d = StCap;
         StCap:   state_d = we_q ? StWr : StDone;
         StWr:    state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Lane selection and extension of the returned memory word for loads.
   always_comb begin
      sel_byte = 8'h00;
      case (addr_q[1:0])
         2'b00:   sel_byte = bus.mem_rdata_i[7:0];
         2'b01:   sel_byte = bus.mem_rdata_i[15:8];
         2'b10:   sel_byte = bus.mem_rdata_i[23:16];
         default: sel_byte = bus.mem_rdata_i[31:24];
      endcase
      sel_half = addr_q[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
      load_val = bus.mem_rdata_i;
      case (funct3_q)
         3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
         3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
         3'b100:  load_val = {24'h000000, sel_byte};
         3'b101:  load_val = {16'h0000, sel_half};
         default: load_val = bus.mem_rdata_i;
      endcase
   end

   // Sub-word store: replace only the addressed lane of the word just read.
   always_comb begin
      merged = bus.mem_rdata_i;
      if (funct3_q[1:0] == 2'b00) begin
         case (addr_q[1:0])
            2'b00:   merged[7:0]   = wdata_q[7:0];
            2'b01:   merged[15:8]  = wdata_q[7:0];
            2'b10:   merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merged[31:16] = wdata_q[15:0];
      end else begin
         merged[15:0] = wdata_q[15:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && bus.req_i) begin
            we_q     <= bus.we_i;
            funct3_q <= bus.funct3_i;
            addr_q   <= bus.addr_i;
            wdata_q  <= bus.wdata_i;
            err_q    <= req_err;
         end
         // wdata_q is reused to hold the merged word for the following WR cycle.
         if (state_q == StCap) begin
            if (we_q) begin
               wdata_q <= merged;
            end else begin
               rdata_q <= load_val;
            end
         end
      end
   end

   assign bus.busy_o      = (state_q != StIdle);
   assign bus.done_o      = (state_q == StDone);
   assign bus.err_o       = (state_q == StDone) && err_q;
   assign bus.rdata_o     = rdata_q;
   assign bus.mem_en_o    = (state_q == StRd) || (state_q == StWr);
   assign bus.mem_we_o    = (state_q == StWr);
   assign bus.mem_wdata_o = (state_q == StWr) ? wdata_q : 32'h0;
   assign bus.mem_addr_o  = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: transaction-level reference model checked every cycle, plus
// directed accesses with hand-computed results and randomized traffic.
module tb_lsu;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   lsu_if bus ();

   lsu dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
      end
   endtask

   // Word memory: read data appears the cycle after a read enable, else 0.
   logic [31:0] mem [256];
   logic [31:0] mem_rd_q;
   always @(posedge clk) begin
      if (bus.mem_en_o === 1'b1 && bus.mem_we_o === 1'b1) mem[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
      mem_rd_q <= (bus.mem_en_o === 1'b1 && bus.mem_we_o === 1'b0) ?
                  mem[bus.mem_addr_o[9:2]] : 32'h0;
   end
   assign bus.mem_rdata_i = mem_rd_q;

   // Transaction-level reference model.
   logic [31:0] ref_mem [256];
   bit          started = 0;
   bit          in_txn  = 0;
   int          k = 0;
   int          lat = 0;
   bit          m_err, m_rd, m_wr, m_load_op;
   logic [31:0] m_word, m_load, exp_rdata, exp_addr;
   logic [7:0]  m_idx;

   task automatic model_accept();
      logic [2:0]  f3;
      logic [31:0] a, wd, old, raw, mask;
      int          sz, sh;
      bit          w, illegal;
      f3 = bus.funct3_i;
      a  = bus.addr_i;
      wd = bus.wdata_i;
      w  = bus.we_i;
      illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (w && f3 >= 4);
      sz = 1 << f3[1:0];
      m_err = illegal || ((a % sz) != 0);
      exp_addr = a & ~32'h3;
      m_idx = a[9:2];
      old = ref_mem[m_idx];
      sh  = 8 * int'(a % 4);
      mask = (sz == 1) ? 32'hFF : (sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
      m_load_op = !w;
      m_rd = 0;
      m_wr = 0;
      if (m_err) begin
         lat = 1;
      end else if (!w) begin
         lat = 3;
         m_rd = 1;
         raw = (old >> sh) & mask;
         if (f3 < 4 && sz < 4 && raw[8 * sz - 1]) raw = raw | ~mask;
         m_load = raw;
      end else if (sz == 4) begin
         lat = 2;
         m_wr = 1;
         m_word = wd;
      end else begin
         lat = 4;
         m_rd = 1;
         m_wr = 1;
         m_word = (old & ~(mask << sh)) | ((wd & mask) << sh);
      end
   endtask

   task automatic model_complete();
      if (!m_err) begin
         if (m_load_op) exp_rdata = m_load;
         else ref_mem[m_idx] = m_word;
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         started   = 1;
         in_txn    = 0;
         k         = 0;
         exp_rdata = 32'h0;
         exp_addr  = 32'h0;
      end else if (in_txn) begin
         if (k == lat) begin
            in_txn = 0;
            k = 0;
         end else begin
            k = k + 1;
            if (k == lat) model_complete();
         end
      end else if (bus.req_i) begin
         model_accept();
         in_txn = 1;
         k = 1;
         if (lat == 1) model_complete();
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      bit e_done, e_rd, e_wr;
      if (started) begin
         e_done = in_txn && (k == lat);
         e_rd   = in_txn && m_rd && (k == 1);
         e_wr   = in_txn && m_wr && (k == lat - 1);
         check("busy_o",      32'(bus.busy_o),   32'(in_txn));
         check("done_o",      32'(bus.done_o),   32'(e_done));
         check("err_o",       32'(bus.err_o),    32'(e_done && m_err));
         check("mem_en_o",    32'(bus.mem_en_o), 32'(e_rd || e_wr));
         check("mem_we_o",    32'(bus.mem_we_o), 32'(e_wr));
         check("mem_wdata_o", bus.mem_wdata_o,   e_wr ? m_word : 32'h0);
         check("mem_addr_o",  bus.mem_addr_o,    exp_addr);
         check("rdata_o",     bus.rdata_o,       exp_rdata);
      end
   end

   int en_cnt = 0, we_cnt = 0, done_cnt = 0;
   always @(negedge clk) begin
      if (bus.mem_en_o === 1'b1) en_cnt = en_cnt + 1;
      if (bus.mem_we_o === 1'b1) we_cnt = we_cnt + 1;
      if (bus.done_o === 1'b1) done_cnt = done_cnt + 1;
   end

   // Issue one request from idle; report latency, error, read data and memory activity.
   task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat_o, output bit err_o,
                         output logic [31:0] rd_o, output int en_o, output int we_o);
      int e0, w0;
      e0 = en_cnt;
      w0 = we_cnt;
      bus.req_i    = 1'b1;
      bus.we_i     = w;
      bus.funct3_i = f3;
      bus.addr_i   = a;
      bus.wdata_i  = wd;
      @(posedge clk);
      #1 bus.req_i = 1'b0;
      lat_o = 0;
      err_o = 0;
      rd_o  = 32'h0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (bus.done_o === 1'b1) begin
            lat_o = c;
            err_o = bus.err_o;
            rd_o  = bus.rdata_o;
            break;
         end
      end
      en_o = en_cnt - e0;
      we_o = we_cnt - w0;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] exp);
      int l, e, w;
      bit er;
      logic [31:0] rd;
      do_req(1'b0, f3, a, 32'h0, l, er, rd, e, w);
      check({name, " latency"}, 32'(l), 32'd3);
      check({name, " err"}, 32'(er), 32'd0);
      check({name, " rdata"}, rd, exp);
   endtask

   initial begin
      int l, e, w, d0, w0;
      bit er;
      logic [31:0] rd;
      for (int i = 0; i < 256; i++) begin
         logic [31:0] v;
         v = $urandom;
         mem[i] <= v;
         ref_mem[i] = v;
      end
      bus.req_i = 1'b0;
      bus.we_i = 1'b0;
      bus.funct3_i = 3'b000;
      bus.addr_i = 32'h0;
      bus.wdata_i = 32'h0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset busy", 32'(bus.busy_o), 32'd0);
      check("reset done", 32'(bus.done_o), 32'd0);
      check("reset err", 32'(bus.err_o), 32'd0);
      check("reset rdata", bus.rdata_o, 32'h0);
      check("reset mem_en", 32'(bus.mem_en_o), 32'd0);
      check("reset mem_addr", bus.mem_addr_o, 32'h0);
      check("reset mem_wdata", bus.mem_wdata_o, 32'h0);
      @(posedge clk);
      #1;

      do_req(1'b1, 3'b010, 32'h8000_0AB0, 32'h1122_3344, l, er, rd, e, w);
      check("SW latency", 32'(l), 32'd2);
      check("SW err", 32'(er), 32'd0);
      check("SW en cycles", 32'(e), 32'd1);
      check("SW we cycles", 32'(w), 32'd1);
      load("LW", 3'b010, 32'h8000_0AB0, 32'h1122_3344);
      load("LB", 3'b000, 32'h8000_0AB3, 32'h0000_0011);
      load("LH", 3'b001, 32'h8000_0AB2, 32'h0000_1122);
      do_req(1'b1, 3'b000, 32'h8000_0AB2, 32'h0000_00F0, l, er, rd, e, w);
      check("SB latency", 32'(l), 32'd4);
      check("SB err", 32'(er), 32'd0);
      load("LW after SB", 3'b010, 32'h8000_0AB0, 32'h11F0_3344);
      load("LB signed", 3'b000, 32'h8000_0AB2, 32'hFFFF_FFF0);
      load("LBU", 3'b100, 32'h8000_0AB2, 32'h0000_00F0);
      do_req(1'b0, 3'b001, 32'h8000_0AB1, 32'h0, l, er, rd, e, w);
      check("misaligned LH latency", 32'(l), 32'd1);
      check("misaligned LH err", 32'(er), 32'd1);
      check("misaligned LH en cycles", 32'(e), 32'd0);
      check("misaligned LH rdata kept", rd, 32'h0000_00F0);

      // SB aborted by reset while in RD.
      d0 = done_cnt;
      w0 = we_cnt;
      bus.req_i = 1'b1;
      bus.we_i = 1'b1;
      bus.funct3_i = 3'b000;
      bus.addr_i = 32'h8000_0AB2;
      bus.wdata_i = 32'h0000_0055;
      @(posedge clk);
      #1 bus.req_i = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("abort busy", 32'(bus.busy_o), 32'd0);
      check("abort rdata cleared", bus.rdata_o, 32'h0);
      repeat (6) @(posedge clk);
      #1;
      check("abort no done", 32'(done_cnt - d0), 32'd0);
      check("abort no write", 32'(we_cnt - w0), 32'd0);
      load("LW after abort", 3'b010, 32'h8000_0AB0, 32'h11F0_3344);

      // Random traffic; requests also arrive while busy and must be ignored.
      for (int i = 0; i < 3000; i++) begin
         bus.req_i    = ($urandom_range(0, 1) == 1);
         bus.we_i     = ($urandom_range(0, 1) == 1);
         bus.funct3_i = 3'($urandom_range(0, 7));
         bus.addr_i   = 32'h8000_0000 | ($urandom & 32'h3F);
         bus.wdata_i  = $urandom;
         @(posedge clk);
         #1;
      end
      bus.req_i = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      for (int i = 0; i < 256; i++) check("memory contents", mem[i], ref_mem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 rst_ni  in  1  reset, synchronous, active-low; sampled on clk_i rising edge.
REQ-003 req_i  in  1  access request; sampled only in IDLE.
REQ-004 we_i  in  1  1 = store, 0 = load.
REQ-005 funct3_i  in  3  size code.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
REQ-006 addr_i  in  32  byte address, little-endian.
REQ-007 wdata_i  in  32  store data, right-justified (SB uses [7:0], SH uses [15:0]).
REQ-008 busy_o  out  1  high whenever state != IDLE.
REQ-009 done_o  out  1  one-cycle completion pulse.
REQ-010 err_o  out  1  one-cycle pulse, coincident with done_o, on misaligned or illegal access.
REQ-011 rdata_o  out  32  load result, extended to 32 bits.
REQ-012 mem_en_o, mem_we_o  out  1 each  memory enable and write enable.
REQ-013 mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-014 mem_wdata_o  out  32  full word written to memory.
REQ-015 mem_rdata_i  in  32  memory read word.
  - Valid in the cycle after a cycle with mem_en_o=1, mem_we_o=0.
  - 0 otherwise.

Function
REQ-016 States: IDLE, RD, CAP, WR, DONE.
REQ-017 In IDLE with req_i=1, the block shall latch we_i, funct3_i, addr_i and wdata_i at the clock edge.
REQ-018 Illegal or misaligned requests shall go IDLE->DONE with err_o=1 and no memory access.
  - Illegal: store with funct3_i[2]=1; any funct3_i of 011, 110 or 111.
  - Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
REQ-019 Loads shall follow IDLE->RD->CAP->DONE->IDLE; done_o is high 3 cycles after the accepting edge.
REQ-020 SW shall follow IDLE->WR->DONE->IDLE; done_o is high 2 cycles after the accepting edge.
REQ-021 SB/SH shall read-modify-write via IDLE->RD->CAP->WR->DONE->IDLE; done_o is high 4 cycles after the accepting edge.
REQ-022 Memory outputs shall be combinational from state.
  - RD: mem_en_o=1, mem_we_o=0.
  - WR: mem_en_o=1, mem_we_o=1, mem_wdata_o = merged word.
  - All other states: mem_en_o=0, mem_we_o=0, mem_wdata_o=0.
REQ-023 mem_addr_o shall always equal the latched aligned address.
REQ-024 In CAP for a load, rdata_o shall be registered from the byte/half selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-025 In CAP for SB/SH, the merged word shall be registered.
  - Merged word = mem_rdata_i with only the addressed byte/half replaced by wdata.
  - All other bytes remain unchanged.
REQ-026 rdata_o shall hold its value until the next successful load reaches DONE.
  - Stores and errored accesses leave rdata_o unchanged.
REQ-027 done_o and err_o shall be high only in DONE.
REQ-028 req_i shall be ignored while busy_o=1; there is no request queuing.
REQ-029 A req_i high in DONE shall be ignored; a new request is accepted only from IDLE.

Reset
REQ-030 While rst_ni=0 at a clock edge, the block shall enter IDLE.
  - Outputs after that edge: rdata_o=0, done_o=0, err_o=0, busy_o=0, mem_en_o=0, mem_we_o=0, mem_wdata_o=0, mem_addr_o=0.
  - All latched request fields are cleared to 0.
REQ-031 Reset in any state, including RD, CAP or WR, shall abort the access.
  - No further memory enable after the reset edge.
  - No done_o pulse for the aborted access.

Verification
REQ-032 Bench shall connect lsu to the team's mem model and cover these scenarios:
  - SW addr 0x80000AB0 data 0x11223344 -> mem_en_o/mem_we_o high 1 cycle; done_o pulses 2 cycles after accept; err_o=0.
  - LW 0x80000AB0 -> done_o 3 cycles after accept, rdata_o=0x11223344.
  - LB 0x80000AB3 -> rdata_o=0x00000011; LH 0x80000AB2 -> rdata_o=0x00001122.
  - SB 0x80000AB2 data 0x000000F0 -> done_o 4 cycles after accept; then LW 0x80000AB0 -> 0x11F03344; LB 0x80000AB2 -> 0xFFFFFFF0; LBU 0x80000AB2 -> 0x000000F0.
  - LH 0x80000AB1 -> done_o=err_o=1 in the cycle after accept; mem_en_o never high; rdata_o keeps its previous value.
  - SB started, rst_ni=0 while in RD -> IDLE, busy_o=0, no WR cycle, no done_o; then LW 0x80000AB0 -> 0x11F03344 (memory unchanged).
